// File: rtl/strum_judge_ctrl.sv
// rtl/strum_judge_ctrl.sv - strum debounce and per-note hit/miss judging with score, streak and multiplier
// Optional feature macro: OVERSTRUM_PENALTY_EN (strum with no note pending costs the streak)
module strum_judge_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SCORE_W         = 16,
    parameter int STREAK_W        = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                strum_raw,
    input  logic [3:0]          buttons,
    input  logic [3:0]          intersections,
    input  logic                note_valid,
    input  logic                note_done,
    output logic                hit,
    output logic                miss,
    output logic [SCORE_W-1:0]  score,
    output logic [STREAK_W-1:0] streak,
    output logic [2:0]          multiplier
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ARMED  = 2'd1;
    localparam logic [1:0] ST_JUDGED = 2'd2;

    logic             sync_q1;
    logic             sync_q2;
    logic             db_level;
    logic [CNT_W-1:0] db_cnt;
    logic             strum_evt;
    logic [1:0]       state;

    logic                match;
    logic [SCORE_W:0]    score_sum;
    logic [SCORE_W-1:0]  score_next;
    logic [STREAK_W-1:0] streak_inc;

    function automatic logic [2:0] mult_of(input logic [STREAK_W-1:0] s);
        if (s >= STREAK_W'(30))      return 3'd4;
        else if (s >= STREAK_W'(20)) return 3'd3;
        else if (s >= STREAK_W'(10)) return 3'd2;
        else                         return 3'd1;
    endfunction

    // Debounced level only follows the synced strum after an unbroken run of disagreement;
    // strum_evt is registered so it lines up with the cycle after the level flips high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            db_level  <= 1'b0;
            db_cnt    <= '0;
            strum_evt <= 1'b0;
        end else begin
            sync_q1   <= strum_raw;
            sync_q2   <= sync_q1;
            strum_evt <= 1'b0;
            if (sync_q2 != db_level) begin
                if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    db_level  <= sync_q2;
                    db_cnt    <= '0;
                    strum_evt <= sync_q2;
                end else begin
                    db_cnt <= db_cnt + CNT_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    always_comb begin
        match      = (buttons == intersections);
        score_sum  = {1'b0, score} + (SCORE_W + 1)'(multiplier);
        score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        streak_inc = (streak == {STREAK_W{1'b1}}) ? streak : streak + STREAK_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            hit        <= 1'b0;
            miss       <= 1'b0;
            score      <= '0;
            streak     <= '0;
            multiplier <= 3'd1;
        end else begin
            hit  <= 1'b0;
            miss <= 1'b0;
            case (state)
                ST_IDLE: begin
                    // A row that arrives and leaves in the same cycle was never playable.
                    if (note_valid && !note_done)
                        state <= ST_ARMED;
`ifdef OVERSTRUM_PENALTY_EN
                    if (strum_evt) begin
                        miss       <= 1'b1;
                        streak     <= '0;
                        multiplier <= 3'd1;
                    end
`endif
                end
                ST_ARMED: begin
                    // Strum takes priority over a simultaneous note_done.
                    if (strum_evt) begin
                        if (match) begin
                            hit        <= 1'b1;
                            score      <= score_next;
                            streak     <= streak_inc;
                            multiplier <= mult_of(streak_inc);
                        end else begin
                            miss       <= 1'b1;
                            streak     <= '0;
                            multiplier <= 3'd1;
                        end
                        state <= note_done ? ST_IDLE : ST_JUDGED;
                    end else if (note_done) begin
                        miss       <= 1'b1;
                        streak     <= '0;
                        multiplier <= 3'd1;
                        state      <= ST_IDLE;
                    end
                end
                ST_JUDGED: begin
                    if (note_done)
                        state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_strum_judge_ctrl.sv
// tb/tb_strum_judge_ctrl.sv - directed bench for strum_judge_ctrl
module tb_strum_judge_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        strum_raw = 1'b0;
    logic [3:0]  buttons = 4'd0;
    logic [3:0]  intersections = 4'd0;
    logic        note_valid = 1'b0;
    logic        note_done = 1'b0;
    logic        hit;
    logic        miss;
    logic [15:0] score;
    logic [7:0]  streak;
    logic [2:0]  multiplier;

    int total = 0;
    int bad = 0;
    int hit_cnt = 0;
    int miss_cnt = 0;
    int both_cnt = 0;

    strum_judge_ctrl #(.DEBOUNCE_CYCLES(4), .SCORE_W(16), .STREAK_W(8)) dut (
        .clock(clock), .reset(reset), .strum_raw(strum_raw), .buttons(buttons),
        .intersections(intersections), .note_valid(note_valid), .note_done(note_done),
        .hit(hit), .miss(miss), .score(score), .streak(streak), .multiplier(multiplier)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (hit === 1'b1) hit_cnt++;
        if (miss === 1'b1) miss_cnt++;
        if (hit === 1'b1 && miss === 1'b1) both_cnt++;
    end

    task automatic cyc;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cyc;
        cyc;
        reset = 1'b0;
        cyc;
    endtask

    task automatic arm(input logic [3:0] b, input logic [3:0] i);
        buttons = b;
        intersections = i;
        note_valid = 1'b1;
        cyc;
        note_valid = 1'b0;
    endtask

    task automatic strum;
        strum_raw = 1'b1;
        repeat (10) cyc;
        strum_raw = 1'b0;
        repeat (10) cyc;
    endtask

    task automatic finish_note;
        note_done = 1'b1;
        cyc;
        note_done = 1'b0;
        cyc;
    endtask

    task automatic play_hit;
        arm(4'b0101, 4'b0101);
        strum;
        finish_note;
    endtask

    task automatic play_miss;
        arm(4'b0001, 4'b0011);
        strum;
        finish_note;
    endtask

    task automatic test_reset;
        cyc;
        total++; if (score !== 16'd0) begin bad++; $display("FAIL reset_score got=%0d exp=0", score); end
        total++; if (streak !== 8'd0) begin bad++; $display("FAIL reset_streak got=%0d exp=0", streak); end
        total++; if (multiplier !== 3'd1) begin bad++; $display("FAIL reset_mult got=%0d exp=1", multiplier); end
        total++; if (hit !== 1'b0 || miss !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b exp=00", hit, miss); end
        reset = 1'b0;
        cyc;
    endtask

    task automatic test_debounce;
        int h0, m0;
        logic exp;
        do_reset;
        arm(4'b0101, 4'b0101);
        h0 = hit_cnt;
        m0 = miss_cnt;
        strum_raw = 1'b1;
        cyc;
        cyc;
        strum_raw = 1'b0;
        repeat (12) cyc;
        total++; if (hit_cnt !== h0 || miss_cnt !== m0) begin bad++; $display("FAIL glitch_ignored got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, h0, m0); end
        strum_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            cyc;
            exp = (i == 7);
            total++; if (hit !== exp) begin bad++; $display("FAIL strum_latency cycle=%0d got=%b exp=%b", i, hit, exp); end
        end
        strum_raw = 1'b0;
        repeat (10) cyc;
        total++; if (hit_cnt !== h0 + 1) begin bad++; $display("FAIL single_evt got=%0d exp=%0d", hit_cnt - h0, 1); end
        finish_note;
    endtask

    task automatic test_single_hit;
        int h0, m0;
        do_reset;
        h0 = hit_cnt;
        m0 = miss_cnt;
        arm(4'b0101, 4'b0101);
        strum;
        total++; if (hit_cnt !== h0 + 1 || miss_cnt !== m0) begin bad++; $display("FAIL hit_pulse got=%0d/%0d exp=1/0", hit_cnt - h0, miss_cnt - m0); end
        total++; if (score !== 16'd1) begin bad++; $display("FAIL hit_score got=%0d exp=1", score); end
        total++; if (streak !== 8'd1) begin bad++; $display("FAIL hit_streak got=%0d exp=1", streak); end
        strum;
        total++; if (hit_cnt !== h0 + 1 || miss_cnt !== m0 || score !== 16'd1) begin bad++; $display("FAIL second_strum got=%0d/%0d score=%0d exp=1/0 score=1", hit_cnt - h0, miss_cnt - m0, score); end
        finish_note;
        total++; if (miss_cnt !== m0) begin bad++; $display("FAIL judged_done got=%0d exp=0", miss_cnt - m0); end
        total++; if (both_cnt !== 0) begin bad++; $display("FAIL hit_and_miss got=%0d exp=0", both_cnt); end
    endtask

    task automatic test_multiplier;
        do_reset;
        repeat (10) play_hit;
        total++; if (streak !== 8'd10) begin bad++; $display("FAIL streak10 got=%0d exp=10", streak); end
        total++; if (multiplier !== 3'd2) begin bad++; $display("FAIL mult2 got=%0d exp=2", multiplier); end
        total++; if (score !== 16'd10) begin bad++; $display("FAIL score10 got=%0d exp=10", score); end
        play_hit;
        total++; if (score !== 16'd12) begin bad++; $display("FAIL score12 got=%0d exp=12", score); end
        repeat (19) play_hit;
        total++; if (score !== 16'd60 || multiplier !== 3'd4) begin bad++; $display("FAIL streak30 score=%0d mult=%0d exp=60/4", score, multiplier); end
        play_miss;
        total++; if (streak !== 8'd0 || multiplier !== 3'd1) begin bad++; $display("FAIL miss_clear streak=%0d mult=%0d exp=0/1", streak, multiplier); end
        total++; if (score !== 16'd60) begin bad++; $display("FAIL miss_score got=%0d exp=60", score); end
    endtask

    task automatic test_note_done_miss;
        int h0, m0;
        do_reset;
        play_hit;
        h0 = hit_cnt;
        m0 = miss_cnt;
        arm(4'b0101, 4'b0101);
        finish_note;
        total++; if (miss_cnt !== m0 + 1 || hit_cnt !== h0) begin bad++; $display("FAIL timeout_miss got=%0d/%0d exp=0/1", hit_cnt - h0, miss_cnt - m0); end
        total++; if (streak !== 8'd0) begin bad++; $display("FAIL timeout_streak got=%0d exp=0", streak); end
    endtask

    task automatic test_strum_and_done;
        int m0;
        do_reset;
        arm(4'b0011, 4'b0011);
        strum_raw = 1'b1;
        repeat (6) cyc;
        note_done = 1'b1;
        cyc;
        note_done = 1'b0;
        total++; if (hit !== 1'b1 || miss !== 1'b0) begin bad++; $display("FAIL strum_wins got=%b%b exp=10", hit, miss); end
        strum_raw = 1'b0;
        repeat (10) cyc;
        m0 = miss_cnt;
        arm(4'b0011, 4'b0011);
        finish_note;
        total++; if (miss_cnt !== m0 + 1) begin bad++; $display("FAIL direct_idle got=%0d exp=1", miss_cnt - m0); end
    endtask

    task automatic test_overstrum;
        int m0;
        do_reset;
        repeat (7) play_hit;
        m0 = miss_cnt;
        strum;
`ifdef OVERSTRUM_PENALTY_EN
        total++; if (streak !== 8'd0 || miss_cnt !== m0 + 1) begin bad++; $display("FAIL overstrum streak=%0d misses=%0d exp=0/1", streak, miss_cnt - m0); end
`else
        total++; if (streak !== 8'd7 || miss_cnt !== m0) begin bad++; $display("FAIL overstrum streak=%0d misses=%0d exp=7/0", streak, miss_cnt - m0); end
`endif
        total++; if (score !== 16'd7) begin bad++; $display("FAIL overstrum_score got=%0d exp=7", score); end
    endtask

    task automatic test_reset_mid;
        int h0;
        do_reset;
        play_hit;
        play_hit;
        play_miss;
        repeat (3) play_hit;
        total++; if (score !== 16'd5 || streak !== 8'd3) begin bad++; $display("FAIL pre_reset score=%0d streak=%0d exp=5/3", score, streak); end
        arm(4'b0101, 4'b0101);
        reset = 1'b1;
        #2;
        total++; if (score !== 16'd0 || streak !== 8'd0 || multiplier !== 3'd1 || hit !== 1'b0 || miss !== 1'b0)
            begin bad++; $display("FAIL async_reset score=%0d streak=%0d mult=%0d hm=%b%b exp=0/0/1/00", score, streak, multiplier, hit, miss); end
        cyc;
        reset = 1'b0;
        cyc;
        h0 = hit_cnt;
        strum;
        total++; if (hit_cnt !== h0) begin bad++; $display("FAIL reset_lost_note got=%0d exp=0", hit_cnt - h0); end
    endtask

    initial begin
        test_reset;
        test_debounce;
        test_single_hit;
        test_multiplier;
        test_note_done_miss;
        test_strum_and_done;
        test_overstrum;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
